// File: rtl/signal_analyser.sv
// signal_analyser: masks an 8-channel probe bus and timestamps every change of the masked value
module signal_analyser #(
    parameter int DATA_WIDTH = 8,
    parameter int TIME_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] channel_mask,
    input  logic                  data_sent,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [TIME_WIDTH-1:0] data_time,
    output logic                  new_data
);
    logic [TIME_WIDTH-1:0] counter;
    logic                  pending;
    logic [DATA_WIDTH-1:0] masked;
    logic                  changed;
    assign masked  = data_in & channel_mask;
    assign changed = masked != data_out;
    // free-running time base, capture on change, hold captured time until readout acknowledges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter   <= '0;
            pending   <= 1'b0;
            data_out  <= '0;
            data_time <= '0;
            new_data  <= 1'b0;
        end else begin
            counter  <= counter + 1'b1;
            new_data <= changed;
            if (changed) begin
                data_out  <= masked;
                data_time <= counter;
                pending   <= 1'b1;
            end else if (data_sent) begin
                pending   <= 1'b0;
                data_time <= counter;
            end else if (!pending) begin
                data_time <= counter;
            end
        end
    end
endmodule

// File: tb/tb_signal_analyser.sv
// tb_signal_analyser: scoreboard bench for signal_analyser, plus a narrow-timestamp instance for wrap
module tb_signal_analyser;
    logic        clk = 0;
    logic        rst = 1;
    logic [7:0]  data_in = 0;
    logic [7:0]  channel_mask = 8'hFF;
    logic        data_sent = 0;
    logic [7:0]  data_out, data_out_w;
    logic [31:0] data_time;
    logic [3:0]  data_time_w;
    logic        new_data, new_data_w;
    int checks = 0;
    int failures = 0;
    typedef struct {
        logic [7:0]  d;
        logic [31:0] t;
        logic        n;
    } exp_t;
    exp_t sbq[$];
    exp_t e;
    logic [31:0] m_cnt, m_time;
    logic [7:0]  m_out;
    logic        m_pend;

    signal_analyser dut (
        .clk(clk), .rst(rst), .data_in(data_in), .channel_mask(channel_mask),
        .data_sent(data_sent), .data_out(data_out), .data_time(data_time), .new_data(new_data)
    );
    signal_analyser #(.DATA_WIDTH(8), .TIME_WIDTH(4)) dut_w (
        .clk(clk), .rst(rst), .data_in(data_in), .channel_mask(channel_mask),
        .data_sent(data_sent), .data_out(data_out_w), .data_time(data_time_w), .new_data(new_data_w)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_cnt = 0; m_time = 0; m_out = 0; m_pend = 0;
        sbq.delete();
    endtask

    // predict the outcome of the coming edge, push it, then advance past the edge
    task automatic tick();
        exp_t x;
        logic [7:0] mk;
        logic ch;
        mk = data_in & channel_mask;
        ch = mk != m_out;
        if (ch) begin
            m_out = mk; m_time = m_cnt; m_pend = 1;
        end else if (data_sent) begin
            m_pend = 0; m_time = m_cnt;
        end else if (!m_pend) begin
            m_time = m_cnt;
        end
        m_cnt++;
        x.d = m_out; x.t = m_time; x.n = ch;
        sbq.push_back(x);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1; data_in = 0; channel_mask = 8'hFF; data_sent = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (data_out !== 8'h00 || data_time !== 32'h0 || new_data !== 1'b0) begin
            failures++;
            $display("FAIL reset: out=%h time=%h new=%b want 00 0 0", data_out, data_time, new_data);
        end
        rst = 0;
    endtask

    task automatic test_first_capture();
        data_in = 8'd69;
        tick();
        e = sbq.pop_front();
        checks++;
        if (data_out !== 8'd69 || data_time !== 32'd0 || new_data !== 1'b1 ||
            data_out !== e.d || data_time !== e.t || new_data !== e.n) begin
            failures++;
            $display("FAIL first_capture: out=%0d time=%0d new=%b want 69 0 1", data_out, data_time, new_data);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            e = sbq.pop_front();
            checks++;
            if (data_out !== 8'd69 || data_time !== 32'd0 || new_data !== 1'b0 ||
                data_time !== e.t || new_data !== e.n) begin
                failures++;
                $display("FAIL hold_pending[%0d]: out=%0d time=%0d new=%b want 69 0 0", i, data_out, data_time, new_data);
            end
        end
    endtask

    task automatic test_data_sent();
        data_sent = 1;
        tick();
        data_sent = 0;
        e = sbq.pop_front();
        checks++;
        if (data_time !== 32'd3 || new_data !== 1'b0 || data_time !== e.t) begin
            failures++;
            $display("FAIL sent_time: time=%0d new=%b want 3 0", data_time, new_data);
        end
        tick();
        e = sbq.pop_front();
        checks++;
        if (data_time !== 32'd4 || data_time !== e.t || data_out !== e.d) begin
            failures++;
            $display("FAIL idle_track: time=%0d want 4", data_time);
        end
    endtask

    task automatic test_new_value();
        data_in = 8'd100;
        tick();
        e = sbq.pop_front();
        checks++;
        if (data_out !== 8'd100 || data_time !== 32'd5 || new_data !== 1'b1 ||
            data_out !== e.d || data_time !== e.t) begin
            failures++;
            $display("FAIL new_value: out=%0d time=%0d new=%b want 100 5 1", data_out, data_time, new_data);
        end
        tick();
        e = sbq.pop_front();
        checks++;
        if (new_data !== 1'b0 || data_time !== 32'd5 || new_data !== e.n) begin
            failures++;
            $display("FAIL pulse_width: new=%b time=%0d want 0 5", new_data, data_time);
        end
    endtask

    task automatic test_mask();
        channel_mask = 8'b1111_0000; data_in = 8'b1101_0010;
        tick();
        e = sbq.pop_front();
        checks++;
        if (data_out !== 8'b1101_0000 || new_data !== 1'b1 || data_time !== e.t) begin
            failures++;
            $display("FAIL mask: out=%b new=%b want 11010000 1", data_out, new_data);
        end
        channel_mask = 8'b0101_0000;
        tick();
        e = sbq.pop_front();
        checks++;
        if (data_out !== 8'b0101_0000 || new_data !== 1'b1 || data_time !== e.t) begin
            failures++;
            $display("FAIL mask_only_change: out=%b new=%b want 01010000 1", data_out, new_data);
        end
        data_in = 8'b1010_1111;
        tick();
        e = sbq.pop_front();
        checks++;
        if (data_out !== 8'b0000_0000 || new_data !== 1'b1 || data_out !== e.d) begin
            failures++;
            $display("FAIL masked_to_zero: out=%b new=%b want 00000000 1", data_out, new_data);
        end
        channel_mask = 8'hFF;
    endtask

    task automatic test_change_with_sent();
        logic [31:0] t0;
        data_in = 8'h3C; data_sent = 1;
        t0 = m_cnt;
        tick();
        data_sent = 0;
        e = sbq.pop_front();
        checks++;
        if (data_out !== 8'h3C || data_time !== t0 || new_data !== 1'b1 || data_time !== e.t) begin
            failures++;
            $display("FAIL change_and_sent: out=%h time=%0d new=%b want 3c %0d 1", data_out, data_time, new_data, t0);
        end
        repeat (2) tick();
        void'(sbq.pop_front());
        e = sbq.pop_front();
        checks++;
        if (data_time !== t0 || new_data !== 1'b0 || data_time !== e.t) begin
            failures++;
            $display("FAIL pending_kept: time=%0d new=%b want %0d 0", data_time, new_data, t0);
        end
        data_sent = 1;
        tick();
        data_sent = 0;
        void'(sbq.pop_front());
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            data_in = 8'(i * 37 + 1);
            data_sent = i[0];
            tick();
            e = sbq.pop_front();
            checks++;
            if (data_out !== e.d || data_time !== e.t || new_data !== e.n || new_data !== 1'b1) begin
                failures++;
                $display("FAIL back_to_back[%0d]: out=%h time=%0d new=%b want %h %0d %b", i, data_out, data_time, new_data, e.d, e.t, e.n);
            end
        end
        data_sent = 1;
        tick();
        data_sent = 0;
        void'(sbq.pop_front());
    endtask

    task automatic test_wrap();
        int guard = 0;
        while (m_cnt[3:0] != 4'hF && guard < 32) begin
            tick();
            void'(sbq.pop_front());
            guard++;
        end
        data_in = ~data_out;
        tick();
        e = sbq.pop_front();
        checks++;
        if (data_time_w !== 4'hF || new_data_w !== 1'b1 || data_time !== e.t) begin
            failures++;
            $display("FAIL wrap_max: time_w=%h new_w=%b time=%0d want f 1 %0d", data_time_w, new_data_w, data_time, e.t);
        end
        data_sent = 1;
        tick();
        data_sent = 0;
        e = sbq.pop_front();
        checks++;
        if (data_time_w !== 4'h0 || data_time !== e.t) begin
            failures++;
            $display("FAIL wrap_zero: time_w=%h want 0", data_time_w);
        end
        tick();
        void'(sbq.pop_front());
        checks++;
        if (data_time_w !== 4'h1) begin
            failures++;
            $display("FAIL wrap_count: time_w=%h want 1", data_time_w);
        end
    endtask

    task automatic test_reset_mid();
        data_in = 8'h55;
        @(negedge clk);
        data_in = 8'hAA;
        #2 rst = 1;
        #1;
        checks++;
        if (data_out !== 8'h00 || data_time !== 32'h0 || new_data !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: out=%h time=%h new=%b want 00 0 0", data_out, data_time, new_data);
        end
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        data_in = 8'h81;
        tick();
        e = sbq.pop_front();
        checks++;
        if (data_out !== 8'h81 || data_time !== 32'd0 || new_data !== 1'b1 || data_out !== e.d) begin
            failures++;
            $display("FAIL post_reset_capture: out=%h time=%0d new=%b want 81 0 1", data_out, data_time, new_data);
        end
    endtask

    initial begin
        test_reset();
        test_first_capture();
        test_data_sent();
        test_new_value();
        test_mask();
        test_change_with_sent();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
